// File: rtl/mod_mul.sv
// Bit-serial interleaved modular multiplier: R = (A * Bm) mod p.
// One bit of A is consumed per clock, MSB first. Each step doubles the
// accumulator, conditionally adds Bm, then reduces by at most 2p so the
// accumulator stays below p for in-contract operands.
module mod_mul #(
   parameter int WIDTH = 256,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] Bm,
   input  logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done
);

   localparam int TW = WIDTH + 2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   p_q, p_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [TW-1:0]      t_s;
   logic [TW-1:0]      p1_s;
   logic [TW-1:0]      p2_s;
   logic [WIDTH-1:0]   red_s;

   // One interleaved step: t = 2*acc + bit*Bm, then subtract 2p or p as needed.
   always_comb begin
      p1_s = {2'b00, p_q};
      p2_s = {1'b0, p_q, 1'b0};
      t_s  = {1'b0, acc_q, 1'b0} + (a_q[cnt_q] ? {2'b00, b_q} : {TW{1'b0}});
      if (t_s >= p2_s) begin
         red_s = WIDTH'(t_s - p2_s);
      end else if (t_s >= p1_s) begin
         red_s = WIDTH'(t_s - p1_s);
      end else begin
         red_s = WIDTH'(t_s);
      end
   end

   // Next-state and datapath update for the IDLE/RUN controller.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = Bm;
               p_d     = p;
               acc_d   = {WIDTH{1'b0}};
               cnt_d   = CNT_W'(WIDTH - 1);
               busy_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               busy_d  = 1'b0;
            end
         end
         S_RUN: begin
            acc_d = red_s;
            if (cnt_q == {CNT_W{1'b0}}) begin
               r_d     = red_s;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         p_q     <= {WIDTH{1'b0}};
         acc_q   <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         r_q     <= {WIDTH{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign R    = r_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
